// File: rtl/fnd_scan_mux.sv
// Source selector and digit scanner for the multiplexed FND display path.
// Scans one digit per SCAN_DIV clocks, switches source only at frame wrap, optional leading-zero blanking.
module fnd_scan_mux #(
   parameter int unsigned        DIGIT_W    = 4,
   parameter int unsigned        NUM_DIGITS = 4,
   parameter int unsigned        SCAN_DIV   = 100000,
   parameter logic [DIGIT_W-1:0] BLANK_CODE = '1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] i_a,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] i_b,
   input  logic                          i_mode,
   input  logic                          i_onOff,
   input  logic                          i_lz_en,
   output logic [DIGIT_W-1:0]            o_digit,
   output logic [NUM_DIGITS-1:0]         o_com,
   output logic                          o_frame_done
);

   localparam int unsigned     PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned     IW         = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]   IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]                 presc;
   logic [IW-1:0]                 idx;
   logic                          mode_q;
   logic                          frame_end_q;
   logic                          tick;
   logic                          frame_end;
   logic [NUM_DIGITS*DIGIT_W-1:0] src;
   logic [DIGIT_W-1:0]            digs [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]         lz_mask;
   logic                          upper_nz;
   logic [DIGIT_W-1:0]            digit_next;
   logic [NUM_DIGITS-1:0]         com_next;

   always_comb begin
      tick      = (presc == PRESC_LAST);
      frame_end = tick && (idx == IDX_LAST);
   end

   always_comb begin
      src = mode_q ? i_b : i_a;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         digs[k] = src[k*DIGIT_W +: DIGIT_W];
      end
   end

   // Walk from the most significant digit down; a digit is a leading zero
   // until the first non-zero digit is seen. Digit 0 is never masked.
   always_comb begin
      upper_nz = 1'b0;
      lz_mask  = '0;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         upper_nz = upper_nz | (digs[NUM_DIGITS-1-j] != '0);
         lz_mask[NUM_DIGITS-1-j] = !upper_nz && (j != NUM_DIGITS-1);
      end
   end

   always_comb begin
      digit_next = digs[idx];
      if (i_onOff) begin
         digit_next = BLANK_CODE;
      end else if (i_lz_en && lz_mask[idx]) begin
         digit_next = BLANK_CODE;
      end
      com_next      = '1;
      com_next[idx] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         presc        <= '0;
         idx          <= '0;
         mode_q       <= 1'b0;
         frame_end_q  <= 1'b0;
         o_digit      <= BLANK_CODE;
         o_com        <= '1;
         o_frame_done <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
         end
         if (frame_end) begin
            mode_q <= i_mode;
         end
         // Extra stage so the pulse lines up with o_com first showing digit 0,
         // which itself trails the index by one register.
         frame_end_q  <= frame_end;
         o_frame_done <= frame_end_q;
         o_digit      <= digit_next;
         o_com        <= com_next;
      end
   end

endmodule

// File: tb/tb_fnd_scan_mux.sv
// Self-checking bench for fnd_scan_mux: directed scenarios plus random stimulus
// compared against an arithmetic model derived from the cycle count since reset.
module tb_fnd_scan_mux;

   localparam int unsigned ND = 4;
   localparam int unsigned SD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a, b;
   logic        mode, onOff, lz_en;
   logic [3:0]  dig0, dig1;
   logic [3:0]  com0, com1;
   logic        fd0, fd1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // model state: edges since reset release, source latched for current frame
   int unsigned n;
   logic        mode_m;
   logic        fe_prev, fe_prev1;

   fnd_scan_mux #(.DIGIT_W(4), .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CODE(4'hF)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_mode(mode),
      .i_onOff(onOff), .i_lz_en(lz_en), .o_digit(dig0), .o_com(com0), .o_frame_done(fd0));

   fnd_scan_mux #(.DIGIT_W(4), .NUM_DIGITS(ND), .SCAN_DIV(1), .BLANK_CODE(4'hF)) dut_fast (
      .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_mode(mode),
      .i_onOff(onOff), .i_lz_en(lz_en), .o_digit(dig1), .o_com(com1), .o_frame_done(fd1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] model_digit(input logic [15:0] src, input int unsigned k,
                                              input logic off, input logic lz);
      logic [15:0] upper;
      upper = src >> (4*k);
      if (off) return 4'hF;
      if (lz && k > 0 && upper == 16'h0) return 4'hF;
      return upper[3:0];
   endfunction

   function automatic logic [15:0] rnd_src();
      logic [15:0] v;
      v = 16'h0;
      for (int i = 0; i < 4; i++)
         if ($urandom_range(1, 0) == 1) v[4*i +: 4] = 4'($urandom_range(15, 1));
      return v;
   endfunction

   // one clock edge: predict from pre-edge state and inputs, then compare after it
   task automatic step();
      int unsigned idx, idx1;
      logic        fe, fe1;
      logic [3:0]  e_dig, e_com, e_com1;
      logic        e_fd, e_fd1;
      idx    = (n / SD) % ND;
      fe     = ((n + 1) % (SD * ND)) == 0;
      idx1   = n % ND;
      fe1    = ((n + 1) % ND) == 0;
      e_dig  = model_digit(mode_m ? b : a, idx, onOff, lz_en);
      e_com  = ~(4'b0001 << idx);
      e_com1 = ~(4'b0001 << idx1);
      e_fd   = fe_prev;
      e_fd1  = fe_prev1;
      @(posedge clk);
      #1;
      chk("digit", dig0, e_dig);
      chk("com", com0, e_com);
      chk("frame_done", fd0, e_fd);
      chk("com_div1", com1, e_com1);
      chk("frame_done_div1", fd1, e_fd1);
      if (fe) mode_m = mode;
      fe_prev  = fe;
      fe_prev1 = fe1;
      n++;
   endtask

   task automatic run(input int unsigned cycles);
      for (int unsigned i = 0; i < cycles; i++) step();
   endtask

   task automatic run_to_digit(input int unsigned d);
      for (int unsigned i = 0; i < SD * ND && ((n / SD) % ND) != d; i++) step();
   endtask

   task automatic model_reset();
      n        = 0;
      mode_m   = 1'b0;
      fe_prev  = 1'b0;
      fe_prev1 = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_digit"}, dig0, 4'hF);
      chk({tag, "_com"}, com0, 4'hF);
      chk({tag, "_fd"}, fd0, 1'b0);
      chk({tag, "_com_div1"}, com1, 4'hF);
      chk({tag, "_digit_div1"}, dig1, 4'hF);
   endtask

   initial begin
      rst_n = 1'b0;
      a = 16'h1234; b = 16'h0; mode = 1'b0; onOff = 1'b0; lz_en = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // basic scan of source A over two frames
      run(2 * SD * ND + 3);

      // mode request mid-frame only takes effect at the next frame
      b = 16'hABCD;
      run_to_digit(1);
      mode = 1'b1;
      run(2 * SD * ND);

      // whole-display blanking during digit 2
      run_to_digit(2);
      onOff = 1'b1;
      run(SD + 2);
      onOff = 1'b0;
      run(3);

      // leading-zero blanking on source A
      mode = 1'b0;
      run(SD * ND);
      lz_en = 1'b1; a = 16'h0050;
      run(SD * ND + 1);
      a = 16'h0000;
      run(SD * ND);
      lz_en = 1'b0;
      run(SD * ND);

      // asynchronous reset mid digit 2, with source B requested
      mode = 1'b1; b = 16'h9876; a = 16'h4321;
      run_to_digit(2);
      step();
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run(2 * SD * ND);

      // random stimulus
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3, 0) == 0) a = rnd_src();
         if ($urandom_range(3, 0) == 0) b = rnd_src();
         if ($urandom_range(15, 0) == 0) mode = ~mode;
         if ($urandom_range(7, 0) == 0) onOff = ~onOff;
         if ($urandom_range(15, 0) == 0) lz_en = ~lz_en;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
